// File: rtl/zeroriscy_mult_div_iter.sv
// Iterative RV32M multiply/divide unit: one radix-2 datapath shared by
// shift-add multiplication and restoring division, 34 cycles per operation.
module zeroriscy_mult_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [1:0]       operator_i,
   input  logic [1:0]       signed_mode_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             ready_o,
   output logic             busy_o
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, ABS, CALC, FINISH} state_t;

   state_t             state;
   state_t             state_next;
   logic [1:0]         op_q;
   logic [1:0]         mode_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      counter;
   logic               neg_res;
   logic               sign_a;
   logic               div_zero;

   logic               is_div;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     rem_sh;
   logic               rem_ge;
   logic [WIDTH-1:0]   rem_sub;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod;

   // Division is signed only when both operands are; MUL signedness is per operand.
   assign is_div = op_q[1];
   assign a_neg  = a_q[WIDTH-1] & (is_div ? (mode_q == 2'b11) : mode_q[0]);
   assign b_neg  = b_q[WIDTH-1] & (is_div ? (mode_q == 2'b11) : mode_q[1]);
   assign a_abs  = a_neg ? -a_q : a_q;
   assign b_abs  = b_neg ? -b_q : b_q;

   // MUL: multiplier sits in the low half and is consumed LSB first.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // DIV: {remainder, quotient} shifted left; the extra remainder bit avoids overflow on compare.
   assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
   assign rem_ge   = rem_sh >= {1'b0, opnd};
   assign rem_sub  = rem_sh[WIDTH-1:0] - opnd;
   assign div_next = rem_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                            : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

   assign prod   = neg_res ? -acc : acc;
   assign busy_o = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         counter  <= '0;
         acc      <= '0;
         op_q     <= '0;
         mode_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         opnd     <= '0;
         neg_res  <= 1'b0;
         sign_a   <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (en_i) begin
                  op_q   <= operator_i;
                  mode_q <= signed_mode_i;
                  a_q    <= op_a_i;
                  b_q    <= op_b_i;
               end
            end
            ABS: begin
               acc      <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
               opnd     <= is_div ? b_abs : a_abs;
               neg_res  <= a_neg ^ b_neg;
               sign_a   <= a_neg;
               div_zero <= (b_q == '0);
               counter  <= CW'(WIDTH - 1);
            end
            CALC: begin
               acc     <= is_div ? div_next : mul_next;
               counter <= counter - CW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (en_i) state_next = ABS;
         ABS:     state_next = en_i ? CALC : IDLE;
         CALC: begin
            if (!en_i)
               state_next = IDLE;
            else if (counter == '0)
               state_next = FINISH;
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Division by zero bypasses sign correction entirely.
   always_comb begin
      result_o = '0;
      ready_o  = 1'b0;
      if (state == FINISH) begin
         ready_o = 1'b1;
         case (op_q)
            2'b00: result_o = prod[WIDTH-1:0];
            2'b01: result_o = prod[2*WIDTH-1:WIDTH];
            2'b10: result_o = div_zero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
            default: result_o = div_zero ? a_q
                                         : (sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]);
         endcase
      end
   end

endmodule
